// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding and
// width helpers for the FIFO pointers and occupancy counter.
package Definitions;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } tx_feeder_state_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy must represent DEPTH itself, hence the extra state.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock circular FIFO with registered full/empty/count flags.
// Optional sticky write-while-full flag under UART_TX_FEEDER_OVERFLOW_EN.
module sync_fifo
  import Definitions::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WORD_LENGHT-1:0]            wr_data,
  input  logic                              wr_en,
  input  logic                              rd_en,
  output logic [WORD_LENGHT-1:0]            rd_data,
  output logic                              full,
  output logic                              empty,
  output logic [count_width(DEPTH)-1:0]     count,
  output logic                              overflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WORD_LENGHT-1:0] mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   wr_acc;
  logic                   rd_acc;

  // Next-state for pointers and occupancy; a write while full is dropped
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == CW'(0));
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; only slots below the occupancy are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

`ifdef UART_TX_FEEDER_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q);
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes ahead of the UART transmitter and hands them over one at a
// time with a send/Tx_ready handshake. Optional macro: UART_TX_FEEDER_OVERFLOW_EN.
module uart_tx_feeder
  import Definitions::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_LENGHT-1:0]        wr_data,
  input  logic                          wr_en,
  input  logic                          Tx_ready,
  output logic [WORD_LENGHT-1:0]        Tx_in,
  output logic                          send,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);

  logic [1:0]             rdy_sync_q, rdy_sync_d;
  logic                   rdy_s;
  tx_feeder_state_e       state_q, state_d;
  logic [WORD_LENGHT-1:0] tx_in_q, tx_in_d;
  logic                   send_q, send_d;
  logic                   pop;
  logic [WORD_LENGHT-1:0] fifo_head;
  logic                   fifo_empty;

  sync_fifo #(
    .WORD_LENGHT (WORD_LENGHT),
    .DEPTH       (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (fifo_empty),
    .count    (count),
    .overflow (overflow)
  );

  always_comb begin
    rdy_sync_d = {rdy_sync_q[0], Tx_ready};
  end

  // Tx_ready arrives from the baud-clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_sync_q <= 2'b00;
    end else begin
      rdy_sync_q <= rdy_sync_d;
    end
  end

  assign rdy_s = rdy_sync_q[1];

  // Handshake sequencing; the head byte is popped straight into Tx_in.
  always_comb begin
    state_d = state_q;
    tx_in_d = tx_in_q;
    send_d  = send_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && rdy_s) begin
          pop     = 1'b1;
          tx_in_d = fifo_head;
          send_d  = 1'b1;
          state_d = SEND;
        end else begin
          send_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (!rdy_s) begin
          send_d  = 1'b0;
          state_d = WAIT_DONE;
        end else begin
          send_d  = 1'b1;
          state_d = SEND;
        end
      end
      WAIT_DONE: begin
        send_d = 1'b0;
        if (rdy_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state with its registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tx_in_q <= '0;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_in_q <= tx_in_d;
      send_q  <= send_d;
    end
  end

  assign Tx_in = tx_in_q;
  assign send  = send_q;
  assign empty = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: a byte-queue model predicts the
// transmitted sequence and FIFO flags while a simple UART model answers send.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int WL    = 8;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_FEEDER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] wr_data;
  logic          wr_en;
  logic          Tx_ready;
  logic [WL-1:0] Tx_in;
  logic          send;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;

  int            checks_total  = 0;
  int            checks_passed = 0;
  logic [7:0]    exp_q[$];
  bit            ovf_model;
  bit            send_prev;
  logic [7:0]    tx_prev;
  int            send_rises;
  int            uart_st;
  int            uart_cnt;
  bit            uart_online;
  int            r0;
  int            n;

  uart_tx_feeder #(.WORD_LENGHT(WL), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .Tx_ready (Tx_ready),
    .Tx_in    (Tx_in),
    .send     (send),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: sample after the edge, advance the model, then move the UART.
  task automatic tick();
    bit         acc;
    logic [7:0] e;
    @(posedge clk);
    #1;
    acc = wr_en && (exp_q.size() < DEPTH);
    if (wr_en && !acc) ovf_model = 1'b1;
    if (send && !send_prev) begin
      send_rises++;
      if (exp_q.size() == 0) check("spurious_send", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("tx_byte", Tx_in, e);
      end
    end else begin
      check("tx_hold", Tx_in, tx_prev);
    end
    if (acc) exp_q.push_back(wr_data);
    check("count", count, exp_q.size());
    check("full", full, exp_q.size() == DEPTH);
    check("empty", empty, exp_q.size() == 0);
    check("overflow", overflow, OVF_EN & ovf_model);
    send_prev = send;
    tx_prev   = Tx_in;
    if (!uart_online) begin
      Tx_ready = 1'b0;
      uart_st  = 0;
    end else begin
      case (uart_st)
        0: begin
          Tx_ready = 1'b1;
          if (send) begin uart_st = 1; uart_cnt = $urandom_range(3, 1); end
        end
        1: begin
          uart_cnt--;
          if (uart_cnt == 0) begin Tx_ready = 1'b0; uart_st = 2; uart_cnt = $urandom_range(8, 4); end
        end
        default: begin
          uart_cnt--;
          if (uart_cnt == 0) begin Tx_ready = 1'b1; uart_st = 0; end
        end
      endcase
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (k < bound && (exp_q.size() != 0 || uart_st != 0 || send)) begin
      tick();
      k++;
    end
    check("drain_in_time", k < bound, 32'd1);
    repeat (6) tick();
  endtask

  task automatic model_reset();
    exp_q.delete();
    ovf_model = 1'b0;
    send_prev = 1'b0;
    tx_prev   = 8'h00;
    uart_st   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; Tx_ready = 1'b0;
    uart_online = 1'b0; send_rises = 0; uart_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_send", send, 32'd0);
    check("rst_tx_in", Tx_in, 32'd0);
    check("rst_full", full, 32'd0);
    check("rst_empty", empty, 32'd1);
    check("rst_count", count, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    rst = 1'b1;
    uart_online = 1'b1;
    Tx_ready = 1'b1;
    repeat (4) tick();

    // Single byte latency: send and Tx_in two cycles after the write.
    push(8'hA5);
    check("a5_count", count, 32'd1);
    tick();
    check("a5_send", send, 32'd1);
    check("a5_data", Tx_in, 32'hA5);
    n = 0;
    while (n < 12 && send) begin tick(); n++; end
    check("a5_send_drop", send, 32'd0);
    drain(200);

    // Burst of three bytes.
    r0 = send_rises;
    push(8'h01); push(8'h02); push(8'h03);
    drain(400);
    check("burst_sends", send_rises - r0, 32'd3);
    check("burst_empty", empty, 32'd1);

    // Transmitter busy: fill to full, then one extra byte is dropped.
    uart_online = 1'b0;
    repeat (8) tick();
    r0 = send_rises;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(254, 0)));
    check("fill_full", full, 32'd1);
    check("fill_count", count, DEPTH);
    push(8'hFF);
    check("ovf_flag", overflow, OVF_EN);
    check("ovf_count", count, DEPTH);
    repeat (6) tick();
    check("offline_no_send", send_rises - r0, 32'd0);
    uart_online = 1'b1;
    drain(2000);

    // Random traffic with the transmitter occasionally going busy.
    for (int i = 0; i < 2500; i++) begin
      wr_en   = ($urandom_range(99, 0) < 40);
      wr_data = 8'($urandom);
      if ($urandom_range(299, 0) == 0) uart_online = !uart_online;
      tick();
    end
    wr_en = 1'b0;
    uart_online = 1'b1;
    drain(3000);

    // Asynchronous reset while a byte is in flight with three more queued.
    r0 = send_rises;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    n = 0;
    while (n < 20 && !(send && exp_q.size() == 3)) begin tick(); n++; end
    check("pre_rst_send", send, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_send", send, 32'd0);
    check("mid_rst_count", count, 32'd0);
    check("mid_rst_empty", empty, 32'd1);
    check("mid_rst_tx_in", Tx_in, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    Tx_ready = 1'b1;
    r0 = send_rises;
    repeat (12) tick();
    check("post_rst_no_send", send_rises - r0, 32'd0);
    push(8'h3C);
    drain(200);
    check("post_rst_one_send", send_rises - r0, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
